// File: rtl/fetch_unit.sv
// Instruction fetch unit: a registered PC drives instruction memory, and
// returned words are captured with their PC into a 2-entry FIFO that feeds
// decode. Redirects flush the FIFO and restart fetch at the new target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          ADDR_BIT_WIDTH = 11,
    parameter int          DATA_BIT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_BIT_WIDTH-1:0] imem_addr,
    input  logic [DATA_BIT_WIDTH-1:0] imem_data,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BIT_WIDTH-1:0] out_inst,
    output logic [31:0]               out_pc,
    output logic [31:0]               fetch_count
);

    // Word-aligned reset target.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]               pc_q, pc_d;
    logic [1:0]                count_q, count_d;
    logic [DATA_BIT_WIDTH-1:0] head_inst_q, head_inst_d;
    logic [31:0]               head_pc_q, head_pc_d;
    logic [DATA_BIT_WIDTH-1:0] tail_inst_q, tail_inst_d;
    logic [31:0]               tail_pc_q, tail_pc_d;
    logic [31:0]               fetch_count_q, fetch_count_d;

    logic       pop;
    logic       pop_fifo;
    logic       issue;
    logic [1:0] cnt_after_pop;

    // The memory address comes straight from the PC flop, so it is stable
    // for the whole cycle while memory samples it on the falling edge.
    assign imem_addr   = pc_q[ADDR_BIT_WIDTH+1:2];
    assign out_valid   = (count_q != 2'd0);
    assign out_inst    = head_inst_q;
    assign out_pc      = head_pc_q;
    assign fetch_count = fetch_count_q;

    // Handshake decode: a redirect still counts an accepted instruction but
    // does not drain the FIFO, since the FIFO is flushed anyway.
    always_comb begin
        pop           = out_valid & out_ready;
        pop_fifo      = pop & ~redirect_valid;
        issue         = ~stall & ~redirect_valid & ((count_q < 2'd2) | pop);
        cnt_after_pop = count_q - {1'b0, pop_fifo};
    end

    // Next-state for PC, FIFO entries, occupancy and the accept counter.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        pc_d          = pc_q;
        count_d       = count_q;
        head_inst_d   = head_inst_q;
        head_pc_d     = head_pc_q;
        tail_inst_d   = tail_inst_q;
        tail_pc_d     = tail_pc_q;
        fetch_count_d = fetch_count_q + {31'd0, pop};

        if (redirect_valid) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            count_d = 2'd0;
        end else begin
            // Popping a full FIFO promotes the tail entry to head.
            if (pop_fifo && (count_q == 2'd2)) begin
                head_inst_d = tail_inst_q;
                head_pc_d   = tail_pc_q;
            end
            // The word on imem_data belongs to the current PC; it lands in
            // the first free slot after any pop this cycle.
            if (issue) begin
                pc_d = pc_q + 32'd4;
                if (cnt_after_pop == 2'd0) begin
                    head_inst_d = imem_data;
                    head_pc_d   = pc_q;
                end else begin
                    tail_inst_d = imem_data;
                    tail_pc_d   = pc_q;
                end
            end
            count_d = cnt_after_pop + {1'b0, issue};
        end
    end

    // Control and head registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            pc_q          <= RESET_PC_ALIGNED;
            count_q       <= 2'd0;
            head_inst_q   <= '0;
            head_pc_q     <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            count_q       <= count_d;
            head_inst_q   <= head_inst_d;
            head_pc_q     <= head_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Tail entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the tail is storage only, read solely when count is 2, so it needs no reset.
        tail_inst_q <= tail_inst_d;
        tail_pc_q   <= tail_pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: streaming with an in-order scoreboard,
// a cycle-by-cycle vector table for backpressure/redirect/stall/wrap/reset,
// and a randomised ready/stall run checked against the sequential PC stream.
module tb_fetch_unit;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          stall;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_inst;
    logic [31:0]   out_pc;
    logic [31:0]   fetch_count;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .ADDR_BIT_WIDTH(AW),
        .DATA_BIT_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: mem[i] = A000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + {{(32-AW){1'b0}}, a};
    endfunction

    // Expected instruction for a byte address.
    function automatic logic [31:0] inst_for_pc(input logic [31:0] pc);
        logic [AW-1:0] a;
        a = pc[AW+1:2];
        return mem_word(a);
    endfunction

    // Memory samples the address on the falling edge.
    always @(negedge clk) imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdv, input logic [31:0] rpc,
                         input logic s, input logic rdy);
        reset          = r;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        stall          = s;
        out_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic          rdv;
        logic [31:0]   rpc;
        logic          stl;
        logic          rdy;
        logic          v;
        logic [31:0]   pc;
        logic [AW-1:0] addr;
        logic [31:0]   fcnt;
    } vec_t;

    vec_t        tbl[24];
    logic [31:0] sb[$];
    int          accepted;

    // Pop the scoreboard on an acceptance that will happen at the coming edge.
    task automatic sb_accept(input string tag);
        logic [31:0] exp_pc;
        if (out_valid && out_ready && !reset) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
                exp_pc = sb.pop_front();
                check({tag, "_pc"}, out_pc, exp_pc);
                check({tag, "_inst"}, out_inst, inst_for_pc(exp_pc));
            end
            accepted++;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

        // Streaming: one fetch pushed per cycle, one accept per cycle after the first.
        tick();
        check("stream_reset_valid", {31'd0, out_valid}, 32'd0);
        check("stream_reset_fcnt", fetch_count, 32'd0);
        accepted = 0;
        sb.delete();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            sb.push_back(32'(4 * i));
            sb_accept("stream");
            tick();
            check($sformatf("stream_fcnt_%0d", i), fetch_count, 32'(accepted));
        end
        check("stream_total", fetch_count, 32'd19);

        // Vector table, one row per cycle; expectations observed after the edge.
        //          rst   rdv   rpc            stl   rdy   v     pc             addr  fcnt
        tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         11'd0,    32'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         11'd1,    32'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         11'd2,    32'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         11'd2,    32'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         11'd2,    32'd0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         11'd2,    32'd0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         11'd3,    32'd1};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         11'd4,    32'd2};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hC,         11'd5,    32'd3};
        tbl[9]  = '{1'b0, 1'b1, 32'h103,       1'b0, 1'b0, 1'b0, 32'h0,         11'd64,   32'd3};
        tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h100,       11'd65,   32'd3};
        tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h100,       11'd66,   32'd3};
        tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h104,       11'd66,   32'd4};
        tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         11'd66,   32'd5};
        tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         11'd66,   32'd5};
        tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h108,       11'd67,   32'd5};
        tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h10C,       11'd68,   32'd6};
        tbl[17] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 32'h0,         11'd2046, 32'd7};
        tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 11'd2047, 32'd7};
        tbl[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 11'd0,    32'd8};
        tbl[20] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         11'd1,    32'd9};
        tbl[21] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         11'd2,    32'd9};
        tbl[22] = '{1'b1, 1'b1, 32'h200,       1'b1, 1'b1, 1'b0, 32'h0,         11'd0,    32'd0};
        tbl[23] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         11'd1,    32'd0};

        for (int r = 0; r < 24; r++) begin
            drive(tbl[r].rst, tbl[r].rdv, tbl[r].rpc, tbl[r].stl, tbl[r].rdy);
            tick();
            check($sformatf("row%0d_valid", r), {31'd0, out_valid}, {31'd0, tbl[r].v});
            check($sformatf("row%0d_addr", r), {{(32-AW){1'b0}}, imem_addr},
                  {{(32-AW){1'b0}}, tbl[r].addr});
            check($sformatf("row%0d_fcnt", r), fetch_count, tbl[r].fcnt);
            if (tbl[r].v) begin
                check($sformatf("row%0d_pc", r), out_pc, tbl[r].pc);
                check($sformatf("row%0d_inst", r), out_inst, inst_for_pc(tbl[r].pc));
            end
            if (tbl[r].rst) begin
                check($sformatf("row%0d_rst_pc", r), out_pc, 32'd0);
                check($sformatf("row%0d_rst_inst", r), out_inst, 32'd0);
            end
        end

        // Random ready/stall: accepted PCs must follow 0,4,8,... with no gap or repeat.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        accepted = 0;
        sb.delete();
        for (int i = 0; i < 100; i++) sb.push_back(32'(4 * i));
        for (int i = 0; i < 80; i++) begin
            drive(1'b0, 1'b0, 32'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
            sb_accept("rand");
            tick();
        end
        check("rand_fcnt", fetch_count, 32'(accepted));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
